// File: rtl/lcd_text_formatter_pkg.sv
// Shared constants, encodings and text helpers for the LCD text formatter.
package lcd_text_formatter_pkg;

  localparam int FRAME_LEN = 32;
  localparam int LINE_LEN  = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_HOUR = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_SEC  = 2'd2,
    SEL_NONE = 2'd3
  } edit_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_BUILD,
    ST_COMMIT
  } state_e;

  localparam logic [47:0]  LBL_TIME  = "TIME  ";
  localparam logic [47:0]  LBL_SET_T = "SET T ";
  localparam logic [47:0]  LBL_SET_A = "SET A ";
  localparam logic [47:0]  LBL_ALARM = "ALARM ";
  localparam logic [23:0]  TXT_ON    = "ON ";
  localparam logic [23:0]  TXT_OFF   = "OFF";
  localparam logic [127:0] TXT_WAKE  = "** WAKE UP! **  ";

  // Packed string literals hold the first character in the top byte.
  function automatic logic [7:0] pick6(input logic [47:0] s, input logic [2:0] pos);
    logic [47:0] t;
    t = s << (8 * pos);
    return t[47:40];
  endfunction

  function automatic logic [7:0] pick3(input logic [23:0] s, input logic [1:0] pos);
    logic [23:0] t;
    t = s << (8 * pos);
    return t[23:16];
  endfunction

  function automatic logic [7:0] pick16(input logic [127:0] s, input logic [3:0] pos);
    logic [127:0] t;
    t = s << (8 * pos);
    return t[127:120];
  endfunction

  // 0 -> 12, 13 -> 1; caller guarantees h <= 23.
  function automatic logic [6:0] hour_12(input logic [4:0] h);
    logic [4:0] r;
    r = (h >= 5'd12) ? (h - 5'd12) : h;
    return (r == 5'd0) ? 7'd12 : {2'b00, r};
  endfunction

endpackage

// File: rtl/lcd_text_formatter_bin2ascii2.sv
// Two-digit binary to ASCII converter with leading zero; "--" when value exceeds limit.
module lcd_text_formatter_bin2ascii2
  import lcd_text_formatter_pkg::*;
(
  input  logic [6:0] value,
  input  logic [6:0] limit,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [6:0] q;
  logic [6:0] r;

  always_comb begin
    q    = value / 7'd10;
    r    = value % 7'd10;
    tens = ASCII_DASH;
    ones = ASCII_DASH;
    if (value <= limit) begin
      tens = ASCII_ZERO + {1'b0, q};
      ones = ASCII_ZERO + {1'b0, r};
    end
  end

endmodule

// File: rtl/lcd_text_formatter.sv
// Builds the 32-char LCD frame from a snapshot of clock/alarm state, one char per cycle,
// then commits it atomically. Define HOUR12_EN for 12-hour display with AM/PM.
//
// state  | meaning
// IDLE   | wait for REFRESH or a pending request
// SNAP   | capture inputs and blink phase, clear pending
// BUILD  | write shadow[idx], idx 0..31
// COMMIT | DISPLAY_DATA <= shadow, DONE pulses next cycle
module lcd_text_formatter
  import lcd_text_formatter_pkg::*;
#(
  parameter int BLINK_TICKS = 500000
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         REFRESH,
  input  logic [1:0]   MODE,
  input  logic [1:0]   EDIT_SEL,
  input  logic [4:0]   HOUR,
  input  logic [5:0]   MIN,
  input  logic [5:0]   SEC,
  input  logic [4:0]   AL_HOUR,
  input  logic [5:0]   AL_MIN,
  input  logic         AL_ON,
  input  logic         RINGING,
  output logic [255:0] DISPLAY_DATA,
  output logic         BUSY,
  output logic         DONE
);

  localparam int               CNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [4:0]       IDX_LAST = 5'(FRAME_LEN - 1);

  state_e                    state, state_nx;
  logic [CNT_W-1:0]          blink_cnt;
  logic                      blink_phase;
  logic                      pending;
  logic [4:0]                idx;
  logic [FRAME_LEN-1:0][7:0] shadow;

  mode_e       snap_mode;
  edit_sel_e   snap_edit;
  logic [4:0]  snap_hour, snap_al_hour;
  logic [5:0]  snap_min, snap_sec, snap_al_min;
  logic        snap_al_on, snap_ringing, snap_phase;

  logic [6:0]  hour_disp, al_hour_disp;
  logic [6:0]  fld_val, fld_lim;
  logic        fld_blank;
  logic        blink_t, blink_a;
  logic [47:0] label;
  logic [7:0]  dig_tens, dig_ones, cur_char;

`ifdef HOUR12_EN
  assign hour_disp    = (snap_hour    > 5'd23) ? 7'h7F : hour_12(snap_hour);
  assign al_hour_disp = (snap_al_hour > 5'd23) ? 7'h7F : hour_12(snap_al_hour);
`else
  assign hour_disp    = {2'b00, snap_hour};
  assign al_hour_disp = {2'b00, snap_al_hour};
`endif

  assign blink_t = snap_phase && (snap_mode == MODE_SET_TIME);
  assign blink_a = snap_phase && (snap_mode == MODE_SET_ALARM);

  always_comb begin
    case (snap_mode)
      MODE_SET_TIME:  label = LBL_SET_T;
      MODE_SET_ALARM: label = LBL_SET_A;
      default:        label = LBL_TIME;
    endcase
  end

  // One digit converter shared across all fields, steered by idx.
  always_comb begin
    fld_val   = 7'd0;
    fld_lim   = 7'd59;
    fld_blank = 1'b0;
    case (idx)
      5'd6, 5'd7: begin
        fld_val   = hour_disp;
        fld_lim   = 7'd23;
        fld_blank = blink_t && (snap_edit == SEL_HOUR);
      end
      5'd9, 5'd10: begin
        fld_val   = {1'b0, snap_min};
        fld_blank = blink_t && (snap_edit == SEL_MIN);
      end
      5'd12, 5'd13: begin
        fld_val   = {1'b0, snap_sec};
        fld_blank = blink_t && (snap_edit == SEL_SEC);
      end
      5'd22, 5'd23: begin
        fld_val   = al_hour_disp;
        fld_lim   = 7'd23;
        fld_blank = blink_a && (snap_edit == SEL_HOUR);
      end
      5'd25, 5'd26: begin
        fld_val   = {1'b0, snap_al_min};
        fld_blank = blink_a && (snap_edit == SEL_MIN);
      end
      default: ;
    endcase
  end

  lcd_text_formatter_bin2ascii2 u_digits (
    .value (fld_val),
    .limit (fld_lim),
    .tens  (dig_tens),
    .ones  (dig_ones)
  );

  always_comb begin
    cur_char = ASCII_SPACE;
    case (idx) inside
      [5'd0:5'd5]:                      cur_char = pick6(label, idx[2:0]);
      5'd6, 5'd9, 5'd12, 5'd22, 5'd25:  cur_char = fld_blank ? ASCII_SPACE : dig_tens;
      5'd7, 5'd10, 5'd13, 5'd23, 5'd26: cur_char = fld_blank ? ASCII_SPACE : dig_ones;
      5'd8, 5'd11, 5'd24:               cur_char = ASCII_COLON;
      5'd14, 5'd15: begin
`ifdef HOUR12_EN
        if (snap_hour <= 5'd23) begin
          if (idx[0])
            cur_char = "M";
          else
            cur_char = (snap_hour < 5'd12) ? "A" : "P";
        end
`endif
      end
      [5'd16:5'd21]:                    cur_char = pick6(LBL_ALARM, idx[2:0]);
      [5'd28:5'd30]:                    cur_char = pick3(snap_al_on ? TXT_ON : TXT_OFF, idx[1:0]);
      default: ;
    endcase
    // The ringing banner takes the whole second line, blink included.
    if (snap_ringing && snap_phase && idx[4])
      cur_char = pick16(TXT_WAKE, idx[3:0]);
  end

  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    case (state)
      ST_IDLE:   if (REFRESH || pending) state_nx = ST_SNAP;
      ST_SNAP: begin
        BUSY     = 1'b1;
        state_nx = ST_BUILD;
      end
      ST_BUILD: begin
        BUSY = 1'b1;
        if (idx == IDX_LAST) state_nx = ST_COMMIT;
      end
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state        <= ST_IDLE;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      pending      <= 1'b0;
      idx          <= '0;
      shadow       <= {FRAME_LEN{ASCII_SPACE}};
      DISPLAY_DATA <= {FRAME_LEN{ASCII_SPACE}};
      DONE         <= 1'b0;
      snap_mode    <= MODE_NORMAL;
      snap_edit    <= SEL_NONE;
      snap_hour    <= '0;
      snap_min     <= '0;
      snap_sec     <= '0;
      snap_al_hour <= '0;
      snap_al_min  <= '0;
      snap_al_on   <= 1'b0;
      snap_ringing <= 1'b0;
      snap_phase   <= 1'b0;
    end else begin
      state <= state_nx;
      DONE  <= (state == ST_COMMIT);

      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // A request landing on the snapshot edge must not be lost.
      if (REFRESH && (state != ST_IDLE))
        pending <= 1'b1;
      else if (state == ST_SNAP)
        pending <= 1'b0;

      case (state)
        ST_SNAP: begin
          snap_mode    <= mode_e'(MODE);
          snap_edit    <= edit_sel_e'(EDIT_SEL);
          snap_hour    <= HOUR;
          snap_min     <= MIN;
          snap_sec     <= SEC;
          snap_al_hour <= AL_HOUR;
          snap_al_min  <= AL_MIN;
          snap_al_on   <= AL_ON;
          snap_ringing <= RINGING;
          snap_phase   <= blink_phase;
          idx          <= '0;
        end
        ST_BUILD: begin
          shadow[idx] <= cur_char;
          idx         <= idx + 1'b1;
        end
        ST_COMMIT: DISPLAY_DATA <= shadow;
        default: ;
      endcase
    end
  end

endmodule
